uart_boot_loader: RTL and testbench

Serial boot loader that sits between the t16450 UART and the RAM port. After `start`, it polls the UART and reads a framed byte stream. It assembles the bytes into 16-bit words and writes them to RAM through the same we/be interface the CPU uses. It holds the CPU off the bus while loading and reports done or error when finished.

---
 rtl/uart_boot_loader.sv | 110 +++++++++++
 tb/tb_uart_boot_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: polls a t16450 UART for an addr/len/data/csum frame and writes it to RAM as 16-bit words
module uart_boot_loader #(
  parameter int         RD_WAIT  = 1,
  parameter int         TIMEOUT  = 50000000,
  parameter logic [2:0] LSR_ADDR = 3'd5,
  parameter logic [2:0] RBR_ADDR = 3'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        uart_cs_n,
  output logic        uart_rd_n,
  output logic        uart_wr_n,
  output logic [2:0]  uart_addr,
  input  logic [7:0]  uart_rd_data,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic [1:0]  ram_be,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, POLL, READ, STORE, WRITE, DONE, ERR} state_t;
  localparam logic [2:0]  RW = 3'(RD_WAIT);
  localparam logic [25:0] TO = 26'(TIMEOUT - 1);
  state_t state, nxt;
  logic [2:0] wcnt, idx;
  logic [25:0] tcnt;
  logic [7:0] rd_byte, lo, csum;
  logic [15:0] ptr, cnt;
  logic hib, csum_ph, strobe, gap;
  assign strobe = (state == POLL || state == READ) && wcnt != RW;
  assign gap = (state == POLL || state == READ) && wcnt == RW;
  assign uart_cs_n = !strobe;
  assign uart_rd_n = !strobe;
  assign uart_wr_n = 1'b1;
  assign uart_addr = !strobe ? 3'd0 : state == POLL ? LSR_ADDR : RBR_ADDR;
  assign ram_we = state == WRITE;
  assign ram_be = {2{ram_we}};
  assign ram_addr = ram_we ? ptr : 16'd0;
  assign ram_wdata = ram_we ? {rd_byte, lo} : 16'd0;
  assign busy = !(state inside {IDLE, DONE, ERR});
  assign cpu_hold = busy;
  assign done = state == DONE;
  assign error = state == ERR;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? POLL : state;
      POLL: nxt = !gap ? POLL : rd_byte[0] ? READ : tcnt == TO ? ERR : POLL;
      READ: nxt = gap ? STORE : READ;
      STORE: nxt = csum_ph ? (rd_byte == csum ? DONE : ERR) : (idx == 3'd4 && hib) ? WRITE : POLL;
      WRITE: nxt = POLL;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wcnt <= '0;
      idx <= '0;
      tcnt <= '0;
      rd_byte <= '0;
      lo <= '0;
      csum <= '0;
      ptr <= '0;
      cnt <= '0;
      hib <= 1'b0;
      csum_ph <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          tcnt <= '0;
          idx <= '0;
          csum <= '0;
          hib <= 1'b0;
          csum_ph <= 1'b0;
        end
        POLL, READ: begin
          wcnt <= gap ? 3'd0 : wcnt + 3'd1;
          if (wcnt == RW - 3'd1) rd_byte <= uart_rd_data;
          if (gap) tcnt <= state == READ ? 26'd0 : rd_byte[0] ? tcnt : tcnt + 26'd1;
        end
        STORE: if (!csum_ph) begin
          if (idx != 3'd4) begin
            idx <= idx + 3'd1;
            if (idx == 3'd0) ptr[7:0] <= rd_byte;
            if (idx == 3'd1) ptr[15:8] <= rd_byte;
            if (idx == 3'd2) cnt[7:0] <= rd_byte;
            if (idx == 3'd3) cnt[15:8] <= rd_byte;
            if (idx == 3'd3 && {rd_byte, cnt[7:0]} == 16'd0) csum_ph <= 1'b1;
          end else begin
            csum <= csum + rd_byte;
            hib <= !hib;
            if (!hib) lo <= rd_byte;
          end
        end
        WRITE: begin
          ptr <= ptr + 16'd1;
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) csum_ph <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: random frames through a UART/RAM model, checked against frame-level expectations
module tb_uart_boot_loader;
  localparam int RDW = 2;
  logic clk = 0, reset_n = 1, start = 0;
  logic uart_cs_n, uart_rd_n, uart_wr_n, ram_we, cpu_hold, busy, done, error;
  logic [2:0] uart_addr;
  logic [7:0] uart_rd_data = 8'h00;
  logic [15:0] ram_addr, ram_wdata;
  logic [1:0] ram_be;
  int vectors = 0, miscompares = 0;
  logic [7:0] rxq[$];
  logic [15:0] wa[$], wd[$], words[$];
  bit rbr_on = 0, rdy = 1, we_prev = 0;
  uart_boot_loader #(.RD_WAIT(RDW), .TIMEOUT(100)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .uart_cs_n(uart_cs_n), .uart_rd_n(uart_rd_n), .uart_wr_n(uart_wr_n),
    .uart_addr(uart_addr), .uart_rd_data(uart_rd_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_be(ram_be),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!uart_rd_n) chk("rd_n_without_cs", {31'd0, uart_cs_n}, 0);
    if (!uart_cs_n && !uart_rd_n && uart_addr == 3'd0) rbr_on = 1;
    else if (rbr_on) begin
      rbr_on = 0;
      if (rxq.size() != 0) void'(rxq.pop_front());
    end
    if (uart_cs_n) rdy = $urandom_range(0, 3) != 0;
    uart_rd_data = uart_addr == 3'd5 ? {7'd0, rdy && rxq.size() != 0} : rxq.size() != 0 ? rxq[0] : 8'hEE;
    if (ram_we) begin
      chk("ram_be", {30'd0, ram_be}, 2'b11);
      chk("we_back_to_back", {31'd0, we_prev}, 0);
      wa.push_back(ram_addr);
      wd.push_back(ram_wdata);
    end
    we_prev = ram_we;
  end
  task automatic reset_chk(input string tag);
    chk({tag, "_uart"}, {26'd0, uart_cs_n, uart_rd_n, uart_wr_n, uart_addr}, 32'h38);
    chk({tag, "_ram"}, {ram_addr, ram_wdata}, 0);
    chk({tag, "_ctl"}, {26'd0, ram_we, ram_be, cpu_hold, busy, done, error}, 0);
  endtask
  task automatic run(input logic [15:0] a, input bit bad, input int cut, input bit poke);
    logic [7:0] fr[$];
    logic [7:0] cs = 0;
    int n = words.size();
    int exp_w, c;
    bit ok = cut < 0 && !bad;
    fr.push_back(a[7:0]);
    fr.push_back(a[15:8]);
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    foreach (words[i]) begin
      fr.push_back(words[i][7:0]);
      fr.push_back(words[i][15:8]);
      cs = cs + words[i][7:0] + words[i][15:8];
    end
    fr.push_back(bad ? cs + 8'd1 : cs);
    if (cut >= 0) while (fr.size() > cut) void'(fr.pop_back());
    exp_w = cut < 0 ? n : cut < 6 ? 0 : (cut - 4) / 2;
    if (exp_w > n) exp_w = n;
    rxq = fr;
    wa.delete();
    wd.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", {31'd0, busy}, 1);
    for (c = 0; c < 3000 && busy; c++) begin
      @(negedge clk);
      start = poke && c == 40;
    end
    start = 0;
    chk("busy_bounded", {31'd0, busy}, 0);
    chk("done", {31'd0, done}, {31'd0, ok});
    chk("error", {31'd0, error}, {31'd0, !ok});
    chk("cpu_hold", {31'd0, cpu_hold}, 0);
    chk("n_writes", wa.size(), exp_w);
    if (cut >= 0) chk("timeout_span", {31'd0, c >= 100 * (RDW + 1)}, 1);
    for (int i = 0; i < exp_w && i < wa.size(); i++) begin
      chk("waddr", {16'd0, wa[i]}, {16'd0, 16'(a + i)});
      chk("wdata", {16'd0, wd[i]}, {16'd0, words[i]});
    end
  endtask
  task automatic rand_words(input int k);
    words.delete();
    repeat (k) words.push_back(16'($urandom));
  endtask
  initial begin
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    reset_chk("reset");
    reset_n = 1;
    @(negedge clk);
    words = {16'h1234, 16'h5678};
    run(16'h0010, 0, -1, 0);
    run(16'h0010, 1, -1, 0);
    words.delete();
    run(16'h2000, 0, -1, 0);
    run(16'h2000, 1, -1, 0);
    rand_words(2);
    run(16'hFFFF, 0, -1, 0);
    repeat (5) begin
      rand_words($urandom_range(1, 8));
      run(16'($urandom), 1'($urandom_range(0, 1)), -1, 0);
    end
    rand_words(3);
    run(16'($urandom), 0, 3, 0);
    rand_words(2);
    run(16'($urandom), 0, 8, 0);
    words.delete();
    rxq = {8'h00, 8'h40, 8'h08, 8'h00};
    repeat (16) rxq.push_back(8'($urandom));
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (60) @(negedge clk);
    #2 reset_n = 0;
    #1 reset_chk("async_reset");
    repeat (2) @(negedge clk);
    rxq.delete();
    reset_n = 1;
    @(negedge clk);
    reset_chk("after_reset");
    rand_words(6);
    run(16'($urandom), 0, -1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
